// File: rtl/arbitro_rr_4a1_if.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr_4a1_if
// Brief    : Bundle between the 4:1 VC arbiter, its four input FIFOs and the
//            downstream transaction-layer FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface arbitro_rr_4a1_if #(
  parameter int DATA_W = 10
) ();
  logic              enable;
  logic [3:0]        empty;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic              almost_full;
  logic [3:0]        pop;
  logic              push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant_id;
  logic              idle;
  logic [1:0]        state_out;

  modport master (
    input  enable, empty, data_in0, data_in1, data_in2, data_in3, almost_full,
    output pop, push, data_out, grant_id, idle, state_out
  );

  modport slave (
    output enable, empty, data_in0, data_in1, data_in2, data_in3, almost_full,
    input  pop, push, data_out, grant_id, idle, state_out
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_rr_4a1.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr_4a1
// Brief    : Drains four VC input FIFOs into one downstream FIFO, one word per
//            cycle, round-robin (fixed priority when ARB_STRICT_PRIO_EN is set).
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr_4a1 #(
  parameter int DATA_W = 10
) (
  input  wire logic         clk,
  input  wire logic         reset_L,
  arbitro_rr_4a1_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_PAUSE  = 2'b11
  } state_e;

  state_e            state_q;
  logic              idle_q;
  logic [1:0]        ptr_q;
  logic              valid_q;
  logic [1:0]        sel_q;
  logic              push_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        grant_q;

  logic [1:0]        base_ptr;
  logic [1:0]        sel_d;
  logic              found;
  logic              valid_d;
  logic [DATA_W-1:0] din_sel;

`ifdef ARB_STRICT_PRIO_EN
  assign base_ptr = 2'd0;
`else
  assign base_ptr = ptr_q;
`endif

  // First non-empty input starting at base_ptr; the 2-bit add wraps 3->0.
  always_comb begin
    sel_d = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && !bus.empty[base_ptr + 2'(k)]) begin
        found = 1'b1;
        sel_d = base_ptr + 2'(k);
      end
    end
  end

  assign valid_d = (state_q == ST_ACTIVE) && bus.enable && !bus.almost_full && found;
  assign bus.pop = valid_d ? (4'b0001 << sel_d) : 4'b0000;

  always_comb begin
    case (sel_q)
      2'd0:    din_sel = bus.data_in0;
      2'd1:    din_sel = bus.data_in1;
      2'd2:    din_sel = bus.data_in2;
      default: din_sel = bus.data_in3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      idle_q  <= 1'b0;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
      push_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= 2'd0;
    end else begin
      // The word popped last cycle is now on the FIFO read port.
      valid_q <= valid_d;
      if (valid_d) begin
        sel_q <= sel_d;
      end
      push_q <= valid_q;
      if (valid_q) begin
        data_q  <= din_sel;
        grant_q <= sel_q;
      end
`ifndef ARB_STRICT_PRIO_EN
      if (valid_d) begin
        ptr_q <= sel_d + 2'd1;
      end
`endif
      case (state_q)
        ST_RESET: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
        ST_IDLE: begin
          if (bus.enable && !(&bus.empty)) begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (!bus.enable || bus.almost_full) begin
            state_q <= ST_PAUSE;
            idle_q  <= 1'b0;
          end else if ((&bus.empty) && !valid_q) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.enable && !bus.almost_full) begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
          end else if (!bus.enable && !valid_q) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RESET;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.push      = push_q;
  assign bus.data_out  = data_q;
  assign bus.grant_id  = grant_q;
  assign bus.idle      = idle_q;
  assign bus.state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_4a1.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_rr_4a1
// Brief    : Self-checking bench for arbitro_rr_4a1 with queue-based FIFO and
//            arbiter reference model; honours ARB_STRICT_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr_4a1;
  localparam int DW       = 10;
  localparam int S_RESET  = 0;
  localparam int S_IDLE   = 1;
  localparam int S_ACTIVE = 2;
  localparam int S_PAUSE  = 3;

  logic clk     = 1'b0;
  logic reset_L = 1'b1;
  always #5 clk = ~clk;

  arbitro_rr_4a1_if #(.DATA_W(DW)) bus ();
  arbitro_rr_4a1 #(.DATA_W(DW)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));

  int n_vec = 0;
  int n_mis = 0;

  logic [DW-1:0] fq0[$];
  logic [DW-1:0] fq1[$];
  logic [DW-1:0] fq2[$];
  logic [DW-1:0] fq3[$];

  int            m_state, m_ptr, m_pid, m_gid;
  bit            m_pv, m_push;
  logic [DW-1:0] m_pw, m_dout;

  int cyc, n_push, n_pop3, last_pop_cyc;
  int obs_g[$];
  int push_cyc[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fsize(int i);
    case (i)
      0: return fq0.size();
      1: return fq1.size();
      2: return fq2.size();
      default: return fq3.size();
    endcase
  endfunction

  function automatic int ftotal();
    return fsize(0) + fsize(1) + fsize(2) + fsize(3);
  endfunction

  function automatic logic [DW-1:0] fpop(int i);
    case (i)
      0: return fq0.pop_front();
      1: return fq1.pop_front();
      2: return fq2.pop_front();
      default: return fq3.pop_front();
    endcase
  endfunction

  function automatic void drive_empty();
    bus.empty = {fsize(3) == 0, fsize(2) == 0, fsize(1) == 0, fsize(0) == 0};
  endfunction

  function automatic void load(int i, logic [DW-1:0] w);
    case (i)
      0: fq0.push_back(w);
      1: fq1.push_back(w);
      2: fq2.push_back(w);
      default: fq3.push_back(w);
    endcase
    drive_empty();
  endfunction

  function automatic void set_din(int i, logic [DW-1:0] w);
    case (i)
      0: bus.data_in0 = w;
      1: bus.data_in1 = w;
      2: bus.data_in2 = w;
      default: bus.data_in3 = w;
    endcase
  endfunction

  function automatic int base_ptr();
`ifdef ARB_STRICT_PRIO_EN
    return 0;
`else
    return m_ptr;
`endif
  endfunction

  function automatic void model_reset();
    m_state = S_RESET; m_ptr = 0; m_pv = 0; m_push = 0;
    m_dout = '0; m_gid = 0; m_pid = 0; m_pw = '0;
    fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
    drive_empty();
  endfunction

  // One clock: check pop mid-cycle, advance the model across the edge, check outputs.
  task automatic tick();
    int sel, nxt;
    bit any_ne;
    logic [3:0] exp_pop;
    #1;
    sel = -1;
    if (m_state == S_ACTIVE && bus.enable && !bus.almost_full)
      for (int k = 0; k < 4; k++)
        if (sel < 0 && fsize((base_ptr() + k) % 4) > 0) sel = (base_ptr() + k) % 4;
    exp_pop = (sel >= 0) ? 4'(1 << sel) : 4'd0;
    check("pop", 32'(bus.pop), 32'(exp_pop));
    any_ne = ftotal() > 0;
    nxt = m_state;
    case (m_state)
      S_RESET:  nxt = S_IDLE;
      S_IDLE:   if (bus.enable && any_ne) nxt = S_ACTIVE;
      S_ACTIVE: if (!bus.enable || bus.almost_full) nxt = S_PAUSE;
                else if (!any_ne && !m_pv) nxt = S_IDLE;
      default:  if (bus.enable && !bus.almost_full) nxt = S_ACTIVE;
                else if (!bus.enable && !m_pv) nxt = S_IDLE;
    endcase
    @(posedge clk);
    #1;
    cyc++;
    m_push = m_pv;
    if (m_pv) begin
      m_dout = m_pw;
      m_gid  = m_pid;
    end
    m_pv = (sel >= 0);
    if (sel >= 0) begin
      m_pid = sel;
      m_pw  = fpop(sel);
      set_din(sel, m_pw);
      drive_empty();
      if (sel == 3) n_pop3++;
      last_pop_cyc = cyc;
`ifndef ARB_STRICT_PRIO_EN
      m_ptr = (sel + 1) % 4;
`endif
    end
    m_state = nxt;
    check("push",      32'(bus.push),      32'(m_push));
    check("data_out",  32'(bus.data_out),  32'(m_dout));
    check("grant_id",  32'(bus.grant_id),  32'(m_gid));
    check("state_out", 32'(bus.state_out), 32'(m_state));
    check("idle",      32'(bus.idle),      32'(m_state == S_IDLE));
    if (bus.push === 1'b1) begin
      n_push++;
      obs_g.push_back(int'(bus.grant_id));
      push_cyc.push_back(cyc);
    end
  endtask

  task automatic run_until_idle(int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      done = (m_state == S_IDLE) && !m_pv && !m_push && (ftotal() == 0);
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    #1;
    model_reset();
    check("rst_pop",      32'(bus.pop),       32'd0);
    check("rst_push",     32'(bus.push),      32'd0);
    check("rst_data_out", 32'(bus.data_out),  32'd0);
    check("rst_grant",    32'(bus.grant_id),  32'd0);
    check("rst_idle",     32'(bus.idle),      32'd0);
    check("rst_state",    32'(bus.state_out), 32'd0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  function automatic int og(int k);
    return (k < obs_g.size()) ? obs_g[k] : -1;
  endfunction

  initial begin
    int exp_g[$];
    int p0, pstart;
    bit seen;
    bus.enable = 1'b1; bus.almost_full = 1'b0; bus.empty = 4'hF;
    bus.data_in0 = '0; bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
    cyc = 0; n_push = 0; n_pop3 = 0; last_pop_cyc = 0;
    model_reset();
    #2;

    // Reset and wake-up
    apply_reset();
    tick();
    check("wake_state", 32'(bus.state_out), 32'd1);
    check("wake_idle",  32'(bus.idle),      32'd1);
    tick(); tick();

    // Round-robin fairness: 3 tagged words per FIFO
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 3; n++) load(i, 10'(i * 16 + n));
    obs_g.delete(); push_cyc.delete();
    run_until_idle(40);
    exp_g.delete();
`ifdef ARB_STRICT_PRIO_EN
    for (int k = 0; k < 12; k++) exp_g.push_back(k / 3);
`else
    for (int k = 0; k < 12; k++) exp_g.push_back(k % 4);
`endif
    check("rr_count", 32'(obs_g.size()), 32'd12);
    for (int k = 0; k < 12; k++) check("rr_gid", 32'(og(k)), 32'(exp_g[k]));
    if (push_cyc.size() == 12) check("rr_span", 32'(push_cyc[11] - push_cyc[0]), 32'd11);
    else check("rr_span_count", 32'(push_cyc.size()), 32'd12);

    // Backpressure
    pstart = n_push;
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 6; n++) load(i, 10'(10'h100 + i * 16 + n));
    for (int n = 0; n < 4; n++) tick();
    bus.almost_full = 1'b1;
    p0 = n_push;
    tick(); tick();
    check("bp_state", 32'(bus.state_out), 32'd3);
    tick(); tick(); tick();
    check("bp_extra_le2", 32'((n_push - p0) <= 2), 32'd1);
    bus.almost_full = 1'b0;
    run_until_idle(100);
    check("bp_total", 32'(n_push - pstart), 32'd24);

    // Single entry on FIFO 3 with pointer at 3, then wrap
    apply_reset();
    tick(); tick();
    load(2, 10'h2AA);
    run_until_idle(20);
    obs_g.delete(); push_cyc.delete(); n_pop3 = 0;
    load(3, 10'h3A5);
    run_until_idle(20);
    check("se_pop3_count", 32'(n_pop3), 32'd1);
    check("se_push_count", 32'(obs_g.size()), 32'd1);
    check("se_gid", 32'(og(0)), 32'd3);
    if (push_cyc.size() > 0) check("se_latency", 32'(push_cyc[0] - last_pop_cyc), 32'd1);
    obs_g.delete();
    load(1, 10'h011); load(0, 10'h010);
    run_until_idle(20);
    check("wrap_first", 32'(og(0)), 32'd0);
    check("wrap_second", 32'(og(1)), 32'd1);

    // Priority order with FIFOs 0 and 2 holding two words each
    apply_reset();
    tick(); tick();
    obs_g.delete();
    load(0, 10'h0A0); load(0, 10'h0A1); load(2, 10'h2B0); load(2, 10'h2B1);
    run_until_idle(30);
    exp_g.delete();
`ifdef ARB_STRICT_PRIO_EN
    exp_g = '{0, 0, 2, 2};
`else
    exp_g = '{0, 2, 0, 2};
`endif
    for (int k = 0; k < 4; k++) check("prio_gid", 32'(og(k)), 32'(exp_g[k]));

    // Randomized traffic with enable/almost_full noise
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        int ch;
        ch = $urandom_range(0, 3);
        if (fsize(ch) < 8) load(ch, 10'($urandom_range(0, 1023)));
      end
      bus.enable      = ($urandom_range(0, 9) != 0);
      bus.almost_full = ($urandom_range(0, 4) == 0);
      tick();
    end
    bus.enable = 1'b1; bus.almost_full = 1'b0;
    run_until_idle(200);

    // Reset while a push is in progress
    for (int i = 0; i < 4; i++) begin load(i, 10'(10'h200 + i)); load(i, 10'(10'h210 + i)); end
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = (bus.push === 1'b1);
    end
    check("mid_push_seen", 32'(seen), 32'd1);
    apply_reset();
    tick(); tick();
    check("post_rst_idle", 32'(bus.idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/arbitro_rr_4a1.md
# arbitro_rr_4a1

Four-input arbiter that drains four virtual-channel input FIFOs into one downstream FIFO of the transaction layer. It picks one non-empty input per cycle (round-robin by default) and pops it. One cycle later it captures the FIFO read data and pushes it downstream, registered. It stops popping while the downstream FIFO reports almost_full or while the link is not active.

## Interface
- DATA_W, 10, word width (matches the FIFO data path)
- clk  in  1  clock, rising-edge
- reset_L  in  1  asynchronous, active-low reset
- enable  in  1  link active; 0 forces PAUSE (no pops)
- empty  in  4  empty flags of input FIFOs 0..3
- data_in0..data_in3  in  DATA_W each  input FIFO read data, valid the cycle after pop
- almost_full  in  1  downstream FIFO almost-full flag
- pop  out  4  one-hot pop to input FIFOs (combinational)
- push  out  1  downstream push (registered)
- data_out  out  DATA_W  downstream write data (registered)
- grant_id  out  2  index of the input whose word is on data_out
- idle  out  1  high in IDLE state
- state_out  out  2  current FSM state

## Operation
- Reset values: pop=0, push=0, data_out=0, grant_id=0, idle=0, state_out=RESET(2'b00), round-robin pointer=0, in-flight register cleared.
- FSM states: RESET(00), IDLE(01), ACTIVE(10), PAUSE(11).
  - RESET→IDLE on the first clock after reset_L deasserts.
  - IDLE→ACTIVE when enable=1 and any empty[i]=0.
  - ACTIVE→PAUSE when enable=0 or almost_full=1. PAUSE→ACTIVE when enable=1 and almost_full=0.
  - ACTIVE→IDLE when all empty=1 and nothing is in flight.
  - PAUSE→IDLE when enable=0 and nothing is in flight.
- Pop rule:
  - pop[i]=1 only in ACTIVE, with almost_full=0 and enable=1, for the selected i with empty[i]=0.
  - At most one bit set. Never popped while empty[i]=1.
- Round-robin selection: search order starts at pointer, wraps 3→0. After a pop of i, pointer=i+1 mod 4. No pop leaves the pointer unchanged.
- Pipeline:
  - At a popping edge, the arbiter registers valid_d=1 and sel_d=i.
  - At the next edge, if valid_d: data_out<=data_in[sel_d], grant_id<=sel_d, push<=1. Otherwise push<=0 and data_out holds.
- In-flight words are always delivered, even if almost_full or enable drops after the pop.
- Reset mid-operation: all state is cleared immediately. In-flight words are discarded.

## Timing
- Pop-to-push latency: a pop sampled at edge E produces push high during cycle E+1..E+2; downstream writes at E+2.
- Sustained throughput is 1 word/cycle while inputs are non-empty and almost_full=0.
- Backpressure: after almost_full rises, at most 2 more words reach the downstream FIFO. Its almost_full threshold must leave ≥2 free entries.
- empty and almost_full are used combinationally in the same cycle as pop. The input FIFO updates empty after the popping edge, so back-to-back pops of a one-entry FIFO cannot occur.
- idle and state_out are registered and change on the clock edge after the transition condition.

## Configuration
- ARB_STRICT_PRIO_EN defined: fixed priority, input 0 highest and input 3 lowest. The pointer is unused and held at 0.
- ARB_STRICT_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset and wake-up:
  - Stimulus: reset_L=0, then release with all empty=1 and enable=1.
  - Response: outputs at reset values; state goes RESET→IDLE, idle=1, pop=0.
- Round-robin fairness:
  - Stimulus: each of the four FIFOs holds 3 words, tagged 0x00i..; almost_full=0.
  - Response: grant_id sequence 0,1,2,3,0,1,2,3,0,1,2,3; 12 pushes on consecutive cycles; then IDLE.
- Backpressure:
  - Stimulus: continuous traffic; almost_full raised for 5 cycles.
  - Response: pop=0 from the same cycle; ≤2 further pushes; state=PAUSE; traffic resumes the cycle after almost_full falls, with no word lost or duplicated.
- Single-entry and wrap:
  - Stimulus: only FIFO 3 holds 1 word, pointer=3.
  - Response: exactly one pop[3]; push two edges later with grant_id=3; pointer wraps to 0.
- Strict priority (ARB_STRICT_PRIO_EN defined):
  - Stimulus: FIFOs 0 and 2 each hold 2 words.
  - Response: grant_id order 0,0,2,2.
- Reset mid-stream:
  - Stimulus: reset_L pulled low while push=1.
  - Response: push, pop and data_out go to 0 immediately (asynchronously); state_out=RESET.
